// File: rtl/dac_sample_pacer.sv
// Paces the 32-bit signed audio stream down to a fixed DAC update rate, converts each sample to
// 12-bit offset-binary and queues it in a small FWFT FIFO behind a valid/ready handshake.
module dac_sample_pacer #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned SAMPLE_HZ  = 8000,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAIN_SHIFT = 0
) (
    input  logic                      Clock,
    input  logic                      nReset,
    input  logic                      Play,
    input  logic [31:0]               Audio_in,
    input  logic                      Clear_overrun,
    input  logic                      Dac_ready,
    output logic                      Dac_valid,
    output logic [11:0]               Dac_data,
    output logic                      Sample_tick,
    output logic [$clog2(DEPTH):0]    Fill,
    output logic                      Overrun,
    output logic [15:0]               Drop_count
);

    localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(DEPTH);

    // ---------------------------------------------------------------------
    // Rate divider
    // ---------------------------------------------------------------------
    logic [CW-1:0] div_cnt_q, div_cnt_d;

    assign Sample_tick = (div_cnt_q == CW'(DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (Sample_tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Gain, saturation and offset-binary conversion
    // ---------------------------------------------------------------------
    logic [39:0] gained;
    logic        sat_pos, sat_neg;
    logic [11:0] new_sample;
    logic        unused_gained_low;

    // 8 guard bits hold any shift up to 8 without losing the true sign.
    assign gained            = {{8{Audio_in[31]}}, Audio_in} << GAIN_SHIFT;
    assign unused_gained_low = ^gained[19:0];

    always_comb begin
        sat_pos    = !gained[39] && (gained[38:31] != 8'h00);
        sat_neg    = gained[39] && (gained[38:31] != 8'hFF);
        new_sample = {~gained[31], gained[30:20]};
        if (sat_pos) begin
            new_sample = 12'hFFF;
        end else if (sat_neg) begin
            new_sample = 12'h000;
        end
        if (!Play) begin
            new_sample = 12'h800;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO; pointers carry an extra wrap bit so full and empty differ
    // ---------------------------------------------------------------------
    logic [11:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, push, pop, drop;

    assign Fill  = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (Fill == (AW + 1)'(DEPTH));
    assign pop   = !empty && Dac_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = Sample_tick && (!full || pop);
    assign drop  = Sample_tick && full && !pop;

    assign Dac_valid = !empty;
    assign Dac_data  = empty ? 12'h800 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= new_sample;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Overrun tracking; a drop outranks a simultaneous clear
    // ---------------------------------------------------------------------
    logic        overrun_d;
    logic [15:0] drop_count_d;

    always_comb begin
        overrun_d    = Overrun;
        drop_count_d = Drop_count;
        if (drop) begin
            overrun_d = 1'b1;
            if (Clear_overrun) begin
                drop_count_d = 16'd1;
            end else if (Drop_count != 16'hFFFF) begin
                drop_count_d = Drop_count + 16'd1;
            end
        end else if (Clear_overrun) begin
            overrun_d    = 1'b0;
            drop_count_d = 16'd0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Overrun    <= 1'b0;
            Drop_count <= 16'd0;
        end else begin
            Overrun    <= overrun_d;
            Drop_count <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer: reset, conversion, pacing, overrun, simultaneous push/pop,
// clear-vs-drop priority and mute, with hand-computed expectations.
module tb_dac_sample_pacer;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        Play = 1'b1;
    logic [31:0] Audio_in = 32'h0;
    logic        Clear_overrun = 1'b0;
    logic        Dac_ready = 1'b1;

    logic        Dac_valid, Sample_tick, Overrun;
    logic [11:0] Dac_data;
    logic [2:0]  Fill;
    logic [15:0] Drop_count;

    logic        g_valid, g_tick, g_overrun;
    logic [11:0] g_data;
    logic [2:0]  g_fill;
    logic [15:0] g_drop_count;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] CONV_IN [7] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
        32'h0010_0000, 32'hFFF0_0000, 32'h4000_0000, 32'hC000_0000};
    localparam logic [11:0] CONV_G0 [7] = '{12'h800, 12'hFFF, 12'h000, 12'h801, 12'h7FF,
        12'hC00, 12'h400};
    localparam logic [11:0] CONV_G2 [7] = '{12'h800, 12'hFFF, 12'h000, 12'h804, 12'h7FC,
        12'hFFF, 12'h000};

    dac_sample_pacer #(
        .CLK_HZ    (1000),
        .SAMPLE_HZ (100),
        .DEPTH     (4),
        .GAIN_SHIFT(0)
    ) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .Play         (Play),
        .Audio_in     (Audio_in),
        .Clear_overrun(Clear_overrun),
        .Dac_ready    (Dac_ready),
        .Dac_valid    (Dac_valid),
        .Dac_data     (Dac_data),
        .Sample_tick  (Sample_tick),
        .Fill         (Fill),
        .Overrun      (Overrun),
        .Drop_count   (Drop_count)
    );

    dac_sample_pacer #(
        .CLK_HZ    (1000),
        .SAMPLE_HZ (100),
        .DEPTH     (4),
        .GAIN_SHIFT(2)
    ) dut_gain (
        .Clock        (Clock),
        .nReset       (nReset),
        .Play         (Play),
        .Audio_in     (Audio_in),
        .Clear_overrun(Clear_overrun),
        .Dac_ready    (Dac_ready),
        .Dac_valid    (g_valid),
        .Dac_data     (g_data),
        .Sample_tick  (g_tick),
        .Fill         (g_fill),
        .Overrun      (g_overrun),
        .Drop_count   (g_drop_count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Returns positioned inside the tick cycle; inputs set now are pushed at the next edge.
    task automatic wait_tick();
        int n = 0;
        while (!Sample_tick && n < 25) begin
            step();
            n++;
        end
        if (!Sample_tick) check("tick_timeout", 32'(Sample_tick), 32'd1);
    endtask

    task automatic push_sample(input logic [31:0] value);
        Audio_in = value;
        wait_tick();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [11:0] held;
        logic [11:0] exp_q [4];
        logic        prev_tick;
        int          pace_err, pace_valid, fill_max;

        // Reset state
        #2;
        check("rst_valid", 32'(Dac_valid), 32'd0);
        check("rst_data", 32'(Dac_data), 32'h800);
        check("rst_fill", 32'(Fill), 32'd0);
        check("rst_tick", 32'(Sample_tick), 32'd0);
        check("rst_ovr", 32'(Overrun), 32'd0);
        check("rst_drop", 32'(Drop_count), 32'd0);
        step();
        nReset = 1'b1;
        n = 0;
        while (!Sample_tick && n < 20) begin
            step();
            n++;
        end
        check("first_tick_edges", 32'(n), 32'd9);

        // Conversion, one sample per case, ready held high
        Dac_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push_sample(CONV_IN[i]);
            check($sformatf("conv%0d_valid", i), 32'(Dac_valid), 32'd1);
            check($sformatf("conv%0d_g0", i), 32'(Dac_data), 32'(CONV_G0[i]));
            check($sformatf("conv%0d_g2", i), 32'(g_data), 32'(CONV_G2[i]));
            step();
            check($sformatf("conv%0d_popped", i), 32'(Dac_valid), 32'd0);
        end

        // Pacing: valid is a one-cycle pulse right after each tick
        prev_tick = Sample_tick;
        pace_err = 0;
        pace_valid = 0;
        fill_max = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (Dac_valid !== prev_tick) pace_err++;
            if (Dac_valid) pace_valid++;
            if (int'(Fill) > fill_max) fill_max = int'(Fill);
            prev_tick = Sample_tick;
        end
        check("pace_align_errors", 32'(pace_err), 32'd0);
        check("pace_valid_count", 32'(pace_valid), 32'd3);
        check("pace_fill_max", 32'(fill_max), 32'd1);

        // Overrun: six ticks into a stalled FIFO
        Dac_ready = 1'b0;
        for (int k = 0; k < 6; k++) push_sample(32'(k + 1) << 20);
        check("ovr_fill", 32'(Fill), 32'd4);
        check("ovr_flag", 32'(Overrun), 32'd1);
        check("ovr_drops", 32'(Drop_count), 32'd2);
        held = Dac_data;
        step();
        check("ovr_hold_data", 32'(Dac_data), 32'(held));
        check("ovr_hold_valid", 32'(Dac_valid), 32'd1);
        Dac_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovr_drain%0d", k), 32'(Dac_data), 32'h801 + 32'(k));
            step();
        end
        check("ovr_drained_valid", 32'(Dac_valid), 32'd0);
        check("ovr_drained_data", 32'(Dac_data), 32'h800);
        Dac_ready = 1'b0;
        Clear_overrun = 1'b1;
        step();
        Clear_overrun = 1'b0;
        check("clr_flag", 32'(Overrun), 32'd0);
        check("clr_drops", 32'(Drop_count), 32'd0);

        // Simultaneous push and pop on a full FIFO
        for (int k = 0; k < 4; k++) push_sample(32'(k + 7) << 20);
        check("sim_full", 32'(Fill), 32'd4);
        Audio_in = 32'h00B0_0000;
        wait_tick();
        Dac_ready = 1'b1;
        step();
        Dac_ready = 1'b0;
        check("sim_fill", 32'(Fill), 32'd4);
        check("sim_ovr", 32'(Overrun), 32'd0);
        check("sim_drops", 32'(Drop_count), 32'd0);
        Dac_ready = 1'b1;
        exp_q = '{12'h808, 12'h809, 12'h80A, 12'h80B};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sim_drain%0d", k), 32'(Dac_data), 32'(exp_q[k]));
            step();
        end
        step();
        step();
        check("idle_ready_fill", 32'(Fill), 32'd0);

        // Clear in the same cycle as a drop: the drop wins
        Dac_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_sample(32'h0010_0000);
        check("cd_pre_drops", 32'(Drop_count), 32'd1);
        Audio_in = 32'h0020_0000;
        wait_tick();
        Clear_overrun = 1'b1;
        step();
        Clear_overrun = 1'b0;
        check("cd_flag", 32'(Overrun), 32'd1);
        check("cd_drops", 32'(Drop_count), 32'd1);
        Dac_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("cd_empty", 32'(Fill), 32'd0);

        // Mute: queued real samples drain before midscale
        Dac_ready = 1'b0;
        Play = 1'b1;
        push_sample(32'h00C0_0000);
        push_sample(32'h00D0_0000);
        Play = 1'b0;
        push_sample(32'h1234_5678);
        push_sample(32'h1234_5678);
        check("mute_fill", 32'(Fill), 32'd4);
        Dac_ready = 1'b1;
        exp_q = '{12'h80C, 12'h80D, 12'h800, 12'h800};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mute_drain%0d", k), 32'(Dac_data), 32'(exp_q[k]));
            check($sformatf("mute_valid%0d", k), 32'(Dac_valid), 32'd1);
            step();
        end
        Play = 1'b1;

        // Reset mid-run with a full FIFO and a pending overrun
        Dac_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_sample(32'h0030_0000);
        check("mr_pre_ovr", 32'(Overrun), 32'd1);
        nReset = 1'b0;
        #1;
        check("mr_valid", 32'(Dac_valid), 32'd0);
        check("mr_data", 32'(Dac_data), 32'h800);
        check("mr_fill", 32'(Fill), 32'd0);
        check("mr_ovr", 32'(Overrun), 32'd0);
        check("mr_drops", 32'(Drop_count), 32'd0);
        step();
        nReset = 1'b1;
        n = 0;
        while (!Sample_tick && n < 20) begin
            step();
            n++;
        end
        check("mr_first_tick_edges", 32'(n), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
